// File: rtl/gpr_retire_clear_queue_pkg.sv
// Shared issue-stage defines used by the GPR retire clear queue.
// Holds the operand encoding fields, register file address widths, the
// layout of one queued retire entry, and a size-to-dword-mask helper.
package gpr_retire_clear_queue_pkg;

  localparam int ISSUE_OP_VALID_H      = 11;
  localparam int ISSUE_OP_VALID_VGPR_L = 10;
  localparam int ISSUE_OP_VALID_SGPR_L = 9;

  localparam logic [1:0] ISSUE_VALID_VGPR_ID = 2'b10;
  localparam logic [2:0] ISSUE_VALID_SGPR_ID = 3'b110;

  localparam int VGPR_ADDR_LENGTH = 10;
  localparam int SGPR_ADDR_LENGTH = 9;

  // One queued clear. SGPR addresses are zero-extended into the VGPR-wide field.
  typedef struct packed {
    logic                        is_vgpr;
    logic [VGPR_ADDR_LENGTH-1:0] addr;
    logic [3:0]                  mask;
  } retire_entry_t;

  localparam int RETIRE_ENTRY_W = $bits(retire_entry_t);

  // size[1] selects 4 dwords, else size[0] selects 2 dwords, else 1 dword.
  function automatic logic [3:0] size_to_mask(input logic [1:0] size);
    if (size[1])      return 4'b1111;
    else if (size[0]) return 4'b0011;
    else              return 4'b0001;
  endfunction

endpackage

// File: rtl/gpr_retire_entry_encode.sv
// Classifies one retire event's destination operand and builds its queue entry.
// Ports:
//   op    - 12-bit issue operand encoding of the destination
//   size  - writeback size code
//   drop  - operand is neither VGPR nor SGPR (constant/literal/special)
//   entry - {is_vgpr, addr, mask} ready to be written into the queue
module gpr_retire_entry_encode
  import gpr_retire_clear_queue_pkg::*;
(
  input  logic [ISSUE_OP_VALID_H:0] op,
  input  logic [1:0]                size,
  output logic                      drop,
  output retire_entry_t             entry
);

  logic is_vgpr;
  logic is_sgpr;

  assign is_vgpr = (op[ISSUE_OP_VALID_H:ISSUE_OP_VALID_VGPR_L] == ISSUE_VALID_VGPR_ID);
  assign is_sgpr = (op[ISSUE_OP_VALID_H:ISSUE_OP_VALID_SGPR_L] == ISSUE_VALID_SGPR_ID);

  assign drop          = !is_vgpr && !is_sgpr;
  assign entry.is_vgpr = is_vgpr;
  assign entry.addr    = is_vgpr ? op[VGPR_ADDR_LENGTH-1:0]
                                 : {1'b0, op[SGPR_ADDR_LENGTH-1:0]};
  assign entry.mask    = size_to_mask(size);

endmodule

// File: rtl/gpr_retire_clear_queue.sv
// Retire-side producer for the issue-stage GPR busy table.
// Collects up to two writeback completion events per cycle (A: vector-memory,
// B: scalar-memory), queues them in order, and drains them onto the busy
// table's VGPR and SGPR LSU clear ports (at most one clear per file per cycle).
// Ports:
//   clk, rst                      - clock, synchronous active-low reset
//   a_valid/a_reg/a_size/a_ready  - channel A retire event handshake
//   b_valid/b_reg/b_size/b_ready  - channel B retire event handshake
//   f_vgpr_lsu_dest_reg_addr/valid - VGPR clear port (base address, dword mask)
//   f_sgpr_lsu_dest_reg_addr/valid - SGPR clear port (base address, dword mask)
//   queue_count                   - current occupancy
//   queue_overflow                - sticky: enqueue accepted with no free slot
module gpr_retire_clear_queue
  import gpr_retire_clear_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        a_valid,
  input  logic [ISSUE_OP_VALID_H:0]   a_reg,
  input  logic [1:0]                  a_size,
  output logic                        a_ready,
  input  logic                        b_valid,
  input  logic [ISSUE_OP_VALID_H:0]   b_reg,
  input  logic [1:0]                  b_size,
  output logic                        b_ready,
  output logic [VGPR_ADDR_LENGTH-1:0] f_vgpr_lsu_dest_reg_addr,
  output logic [3:0]                  f_vgpr_lsu_dest_reg_valid,
  output logic [SGPR_ADDR_LENGTH-1:0] f_sgpr_lsu_dest_reg_addr,
  output logic [3:0]                  f_sgpr_lsu_dest_reg_valid,
  output logic [PTR_W:0]              queue_count,
  output logic                        queue_overflow
);

  localparam logic [PTR_W:0]   DEPTH_C    = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   DEPTH_M1_C = (PTR_W+1)'(DEPTH - 1);
  localparam logic [PTR_W+1:0] DEPTH_W_C  = (PTR_W+2)'(DEPTH);

  logic [RETIRE_ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]          rd_ptr;
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W:0]            count;

  logic          drop_a, drop_b;
  retire_entry_t ent_a, ent_b;
  logic          enq_a, enq_b;
  logic [1:0]    enq_n;
  logic [1:0]    deq_n;
  logic          pair;
  logic          overflow_now;
  retire_entry_t h0, h1;

  gpr_retire_entry_encode u_enc_a (.op(a_reg), .size(a_size), .drop(drop_a), .entry(ent_a));
  gpr_retire_entry_encode u_enc_b (.op(b_reg), .size(b_size), .drop(drop_b), .entry(ent_b));

  // Ready looks only at registered occupancy; A is allowed one slot deeper than B.
  assign a_ready = (count < DEPTH_C);
  assign b_ready = (count < DEPTH_M1_C);

  // Dropped operands complete the handshake but never occupy a slot.
  assign enq_a = a_valid && a_ready && !drop_a;
  assign enq_b = b_valid && b_ready && !drop_b;
  assign enq_n = {1'b0, enq_a} + {1'b0, enq_b};

  assign overflow_now = ((PTR_W+2)'(count) + (PTR_W+2)'(enq_n)) > DEPTH_W_C;

  assign h0 = retire_entry_t'(mem[rd_ptr]);
  assign h1 = retire_entry_t'(mem[rd_ptr + PTR_W'(1)]);

  // The second entry can ride along only when it targets the other register file.
  assign pair = (count[PTR_W:1] != '0) && (h1.is_vgpr != h0.is_vgpr);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    f_vgpr_lsu_dest_reg_addr  = '0;
    f_vgpr_lsu_dest_reg_valid = '0;
    f_sgpr_lsu_dest_reg_addr  = '0;
    f_sgpr_lsu_dest_reg_valid = '0;
    deq_n                     = 2'd0;
    if (count != '0) begin
      deq_n = pair ? 2'd2 : 2'd1;
      if (h0.is_vgpr) begin
        f_vgpr_lsu_dest_reg_addr  = h0.addr;
        f_vgpr_lsu_dest_reg_valid = h0.mask;
        if (pair) begin
          f_sgpr_lsu_dest_reg_addr  = h1.addr[SGPR_ADDR_LENGTH-1:0];
          f_sgpr_lsu_dest_reg_valid = h1.mask;
        end
      end else begin
        f_sgpr_lsu_dest_reg_addr  = h0.addr[SGPR_ADDR_LENGTH-1:0];
        f_sgpr_lsu_dest_reg_valid = h0.mask;
        if (pair) begin
          f_vgpr_lsu_dest_reg_addr  = h1.addr;
          f_vgpr_lsu_dest_reg_valid = h1.mask;
        end
      end
    end
  end

  // NOTE: non-blocking assignments on all state so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      queue_overflow <= 1'b0;
    end else begin
      rd_ptr <= rd_ptr + PTR_W'(deq_n);
      wr_ptr <= wr_ptr + PTR_W'(enq_n);
      count  <= count + (PTR_W+1)'(enq_n) - (PTR_W+1)'(deq_n);
      if (overflow_now) queue_overflow <= 1'b1;
    end
  end

  // NOTE: storage is not reset; occupancy alone decides which slots are meaningful.
  // A lands first; B takes the following slot when both enqueue together.
  always_ff @(posedge clk) begin
    if (rst && enq_a) mem[wr_ptr] <= ent_a;
    if (rst && enq_b) mem[wr_ptr + PTR_W'(enq_a)] <= ent_b;
  end

  assign queue_count = count;

endmodule

// File: tb/tb_gpr_retire_clear_queue.sv
module tb_gpr_retire_clear_queue;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid;
  logic [11:0] a_reg, b_reg;
  logic [1:0]  a_size, b_size;
  logic        a_ready, b_ready;
  logic [9:0]  v_addr;
  logic [3:0]  v_valid;
  logic [8:0]  s_addr;
  logic [3:0]  s_valid;
  logic [3:0]  q_count;
  logic        q_ovf;

  gpr_retire_clear_queue #(.DEPTH(DEPTH), .PTR_W(3)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .a_valid                   (a_valid),
    .a_reg                     (a_reg),
    .a_size                    (a_size),
    .a_ready                   (a_ready),
    .b_valid                   (b_valid),
    .b_reg                     (b_reg),
    .b_size                    (b_size),
    .b_ready                   (b_ready),
    .f_vgpr_lsu_dest_reg_addr  (v_addr),
    .f_vgpr_lsu_dest_reg_valid (v_valid),
    .f_sgpr_lsu_dest_reg_addr  (s_addr),
    .f_sgpr_lsu_dest_reg_valid (s_valid),
    .queue_count               (q_count),
    .queue_overflow            (q_ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: an ordered list of pending clears.
  typedef struct {
    bit is_v;
    int addr;
    int mask;
  } clr_t;

  clr_t model_q[$];

  function automatic int mask_of(input int size);
    if (size >= 2) return 15;
    if (size == 1) return 3;
    return 1;
  endfunction

  // Returns 1 and the clear if the operand names a GPR, else 0.
  function automatic bit classify(input int r, input int size, output clr_t c);
    c.mask = mask_of(size);
    if ((r >> 10) == 2) begin
      c.is_v = 1; c.addr = r % 1024; return 1;
    end
    if ((r >> 9) == 6) begin
      c.is_v = 0; c.addr = r % 512; return 1;
    end
    c.is_v = 0; c.addr = 0; return 0;
  endfunction

  // Check the current outputs against the model, apply inputs, advance one clock.
  task automatic step(input bit av, input int ar, input int as_,
                      input bit bv, input int br, input int bs, input bit rs);
    int ev_a = 0, ev_m = 0, es_a = 0, es_m = 0, pops = 0;
    bit exp_ar, exp_br;
    clr_t c;
    a_valid = av; a_reg = 12'(ar); a_size = 2'(as_);
    b_valid = bv; b_reg = 12'(br); b_size = 2'(bs);
    rst = rs;

    exp_ar = (model_q.size() <= DEPTH - 1);
    exp_br = (model_q.size() <= DEPTH - 2);
    if (model_q.size() > 0) begin
      pops = 1;
      if (model_q[0].is_v) begin ev_a = model_q[0].addr; ev_m = model_q[0].mask; end
      else begin es_a = model_q[0].addr; es_m = model_q[0].mask; end
      if (model_q.size() >= 2 && model_q[1].is_v != model_q[0].is_v) begin
        pops = 2;
        if (model_q[1].is_v) begin ev_a = model_q[1].addr; ev_m = model_q[1].mask; end
        else begin es_a = model_q[1].addr; es_m = model_q[1].mask; end
      end
    end

    check("vgpr_addr",  32'(v_addr),  ev_a);
    check("vgpr_valid", 32'(v_valid), ev_m);
    check("sgpr_addr",  32'(s_addr),  es_a);
    check("sgpr_valid", 32'(s_valid), es_m);
    check("count",      32'(q_count), model_q.size());
    check("a_ready",    32'(a_ready), 32'(exp_ar));
    check("b_ready",    32'(b_ready), 32'(exp_br));
    check("overflow",   32'(q_ovf),   0);

    @(posedge clk);
    #1;
    if (!rs) begin
      model_q.delete();
    end else begin
      repeat (pops) void'(model_q.pop_front());
      if (av && exp_ar && classify(ar, as_, c)) model_q.push_back(c);
      if (bv && exp_br && classify(br, bs, c)) model_q.push_back(c);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 1);
  endtask

  function automatic int rand_reg();
    case ($urandom_range(0, 4))
      0, 1:    return 'h800 | int'($urandom_range(0, 1023));
      2, 3:    return 'hC00 | int'($urandom_range(0, 511));
      default: return ($urandom_range(0, 1) == 1) ? int'('hE00 | $urandom_range(0, 511))
                                                   : int'($urandom_range(0, 2047));
    endcase
  endfunction

  initial begin
    a_valid = 0; b_valid = 0; a_reg = '0; b_reg = '0; a_size = '0; b_size = '0;
    rst = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, then a single 4-dword VGPR clear.
    idle(1);
    step(1, 'h805, 2, 0, 0, 0, 1);
    idle(2);

    // Dual-file pair drains in one cycle.
    step(1, 'h803, 1, 1, 'hC10, 0, 1);
    idle(2);

    // Same-file conflict drains over two cycles.
    step(1, 'h808, 0, 1, 'h809, 0, 1);
    idle(3);

    // Fill with two SGPR events per cycle against a one-per-cycle drain.
    for (int i = 0; i < 10; i++)
      step(1, 'hC00 | (2 * i), i % 3, 1, 'hC00 | (2 * i + 1), (i + 1) % 3, 1);
    idle(DEPTH + 2);

    // Literal operand is accepted and dropped.
    step(1, 'h0FF, 2, 0, 0, 0, 1);
    idle(1);

    // Build a backlog, then reset mid-burst.
    for (int i = 0; i < 3; i++)
      step(1, 'hC20 | i, 0, 1, 'hC30 | i, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    idle(4);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, rand_reg(), $urandom_range(0, 3),
           $urandom_range(0, 3) != 0, rand_reg(), $urandom_range(0, 3),
           $urandom_range(0, 199) != 0);
    end
    idle(DEPTH + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
